// File: rtl/fifo_burst_reader_if.sv
// Signal bundle between the burst reader, the FIFO read port and the downstream
// stream consumer. The master modport is the reader's view; slave is the environment's.
interface fifo_burst_reader_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
);
  localparam int LEN_W = $clog2(MAX_BURST) + 1;

  // FIFO read side
  logic             o_Rd_En;
  logic             i_Rd_DV;
  logic [WIDTH-1:0] i_Rd_Data;
  logic             i_Empty;
  logic             i_AE_Flag;

  // Burst control
  logic [LEN_W-1:0] i_Burst_Len;
  logic             i_Flush;

  // Stream out: a word transfers on a cycle where o_Tx_DV and i_Tx_Ready are both
  // high; o_Tx_DV never waits on i_Tx_Ready and, once high, o_Tx_DV/o_Tx_Data/
  // o_Tx_Last hold until that transfer.
  logic             o_Tx_DV;
  logic [WIDTH-1:0] o_Tx_Data;
  logic             o_Tx_Last;
  logic             i_Tx_Ready;

  // Status
  logic             o_Busy;
  logic             o_Err;

  modport master (
    output o_Rd_En, o_Tx_DV, o_Tx_Data, o_Tx_Last, o_Busy, o_Err,
    input  i_Rd_DV, i_Rd_Data, i_Empty, i_AE_Flag, i_Burst_Len, i_Flush, i_Tx_Ready
  );

  modport slave (
    input  o_Rd_En, o_Tx_DV, o_Tx_Data, o_Tx_Last, o_Busy, o_Err,
    output i_Rd_DV, i_Rd_Data, i_Empty, i_AE_Flag, i_Burst_Len, i_Flush, i_Tx_Ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side master for a single-clock DPRAM FIFO: issues reads, absorbs the RAM
// read latency in a small circular buffer and emits valid/ready bursts with a last marker.
module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  fifo_burst_reader_if.master  bus,
  output logic [1:0]           o_State
);

  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  localparam logic [LEN_W-1:0] ONE_LEN   = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BURST);
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [LEN_W-1:0] len_q,    len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] sent_q,   sent_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q,    occ_d;
  logic [CNT_W-1:0] infl_q,   infl_d;
  logic             err_q,    err_d;
  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];

  logic [LEN_W-1:0] len_clamped;
  logic [SUM_W-1:0] committed;
  logic             rd_en;
  logic             push;
  logic             pop;
  logic             tx_dv;

  always_comb begin
    len_clamped = bus.i_Burst_Len;
    if (bus.i_Burst_Len == '0) begin
      len_clamped = ONE_LEN;
    end else if (bus.i_Burst_Len > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end
  end

  // Words already buffered plus words still coming back from the RAM; capping this
  // at BUF_DEPTH is what guarantees every returning word has a free slot.
  assign committed = SUM_W'(occ_q) + SUM_W'(infl_q);

  assign rd_en = (state_q == BURST) && !bus.i_Empty &&
                 (issued_q < len_q) && (committed < DEPTH_SUM);

  // A data-valid with nothing outstanding is not ours to keep.
  assign push  = bus.i_Rd_DV && (infl_q != '0);
  assign tx_dv = (occ_q != '0);
  assign pop   = tx_dv && bus.i_Tx_Ready;

  always_comb begin
    infl_d = infl_q;
    case ({rd_en, push})
      2'b10:   infl_d = infl_q + CNT_W'(1);
      2'b01:   infl_d = infl_q - CNT_W'(1);
      default: infl_d = infl_q;
    endcase

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.i_Rd_Data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    err_d = err_q | (bus.i_Rd_DV && (infl_q == '0));
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    if (rd_en) issued_d = issued_q + ONE_LEN;
    if (pop)   sent_d   = sent_q + ONE_LEN;

    case (state_q)
      IDLE: begin
        if (!bus.i_AE_Flag && !bus.i_Empty) begin
          state_d  = BURST;
          len_d    = len_clamped;
          issued_d = '0;
          sent_d   = '0;
        end else if (bus.i_Flush && !bus.i_Empty) begin
          state_d  = BURST;
          len_d    = ONE_LEN;
          issued_d = '0;
          sent_d   = '0;
        end
      end
      BURST: begin
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (sent_d == len_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      len_q    <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.o_Rd_En   = rd_en;
  assign bus.o_Tx_DV   = tx_dv;
  assign bus.o_Tx_Data = mem_q[rd_ptr_q];
  assign bus.o_Tx_Last = tx_dv && (sent_q == (len_q - ONE_LEN));
  assign bus.o_Busy    = (state_q != IDLE);
  assign bus.o_Err     = err_q;
  assign o_State       = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO with variable read latency feeds
// the reader; accepted words are scored against an expected data/last queue.
module tb_fifo_burst_reader;

  localparam int WIDTH     = 8;
  localparam int BUF_DEPTH = 4;
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = $clog2(MAX_BURST) + 1;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  fifo_burst_reader_if #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) bus ();
  logic [1:0] state_dbg;

  fifo_burst_reader #(
    .WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_l),
    .bus     (bus),
    .o_State (state_dbg)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } rd_t;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] fifo_q[$];
  rd_t              rd_pipe[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_last_q[$];
  int               acc_cyc_q[$];
  logic             busy_log[$];
  int               cyc          = 0;
  int               acc_count    = 0;
  int               reads_issued = 0;
  int               bursts       = 0;
  int               last_due     = 0;
  bit               ready_rand   = 1'b0;
  logic             ready_fix    = 1'b1;
  bit               lat_rand     = 1'b0;
  bit               inject       = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > MAX_BURST) return MAX_BURST;
    return l;
  endfunction

  // FIFO model, read-latency pipe, ready driver and monitor/scoreboard.
  // Inputs change 1ns after the falling edge; outputs are sampled 1ns later.
  initial begin
    logic             hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;
    logic             prev_busy = 1'b0;
    rd_t              r;
    int               lat;
    bus.i_Rd_DV    = 1'b0;
    bus.i_Rd_Data  = '0;
    bus.i_Empty    = 1'b1;
    bus.i_AE_Flag  = 1'b1;
    bus.i_Tx_Ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rd_pipe.size() > 0 && rd_pipe[0].due <= cyc) begin
        r = rd_pipe.pop_front();
        bus.i_Rd_DV   = 1'b1;
        bus.i_Rd_Data = r.data;
      end else if (inject) begin
        bus.i_Rd_DV   = 1'b1;
        bus.i_Rd_Data = 8'hEE;
        inject        = 1'b0;
      end else begin
        bus.i_Rd_DV   = 1'b0;
        bus.i_Rd_Data = '0;
      end
      bus.i_Empty    = (fifo_q.size() == 0);
      bus.i_AE_Flag  = (fifo_q.size() < clamp_len(int'(bus.i_Burst_Len)));
      bus.i_Tx_Ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
      #1;
      busy_log.push_back(bus.o_Busy);
      if (rst_l) begin
        if (bus.o_Busy && !prev_busy) bursts++;
        if (hold_pend) begin
          chk("tx_hold_dv", bus.o_Tx_DV, 1);
          chk("tx_hold_data", bus.o_Tx_Data, hold_data);
        end
        if (bus.o_Rd_En) begin
          chk("rd_en_when_empty", bus.i_Empty, 0);
          reads_issued++;
          if (fifo_q.size() > 0) begin
            lat      = lat_rand ? int'($urandom_range(1, 3)) : 1;
            r.data   = fifo_q.pop_front();
            r.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = r.due;
            rd_pipe.push_back(r);
          end
        end
        if (bus.o_Tx_DV && bus.i_Tx_Ready) begin
          acc_count++;
          acc_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(bus.o_Tx_Data), 32'hFFFF_FFFF);
          end else begin
            chk("tx_data", bus.o_Tx_Data, exp_q.pop_front());
            chk("tx_last", bus.o_Tx_Last, exp_last_q.pop_front());
          end
        end
        hold_pend = bus.o_Tx_DV && !bus.i_Tx_Ready;
        hold_data = bus.o_Tx_Data;
        prev_busy = bus.o_Busy;
      end else begin
        hold_pend = 1'b0;
        prev_busy = 1'b0;
      end
      cyc++;
    end
  end

  task automatic clear_model();
    fifo_q.delete();
    rd_pipe.delete();
    exp_q.delete();
    exp_last_q.delete();
    acc_cyc_q.delete();
    acc_count    = 0;
    reads_issued = 0;
    bursts       = 0;
    last_due     = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic load(input int n, input int base, input bit rand_data);
    logic [WIDTH-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rand_data ? WIDTH'($urandom) : WIDTH'(base + i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    int k = 0;
    while (acc_count < n && k < budget) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk(tag, 32'(acc_count), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_Burst_Len = LEN_W'(4);
    bus.i_Flush     = 1'b0;

    // 1: reset with 8 words waiting, then two back-to-back 4-word bursts
    load(8, 1, 1'b0);
    for (int i = 0; i < 8; i++) exp_last_q.push_back(i % 4 == 3);
    wait_cycles(3);
    chk("rst_rd_en", bus.o_Rd_En, 0);
    chk("rst_tx_dv", bus.o_Tx_DV, 0);
    chk("rst_tx_last", bus.o_Tx_Last, 0);
    chk("rst_tx_data", bus.o_Tx_Data, 0);
    chk("rst_busy", bus.o_Busy, 0);
    chk("rst_err", bus.o_Err, 0);
    @(negedge clk);
    rst_l = 1'b1;
    wait_acc("t1_words", 8, 100);
    chk("t1_back_to_back", 32'(acc_cyc_q[3] - acc_cyc_q[0]), 3);
    chk("t1_idle_after_last", busy_log[acc_cyc_q[3] + 1], 0);
    chk("t1_bursts", 32'(bursts), 2);

    // 2: backpressure holds the first word; only one burst of reads issued
    ready_fix = 1'b0;
    do_reset();
    load(8, 8'h11, 1'b0);
    for (int i = 0; i < 8; i++) exp_last_q.push_back(i % 4 == 3);
    wait_cycles(20);
    chk("t2_reads_capped", 32'(reads_issued), 4);
    chk("t2_dv_stuck", bus.o_Tx_DV, 1);
    chk("t2_head_data", bus.o_Tx_Data, 8'h11);
    chk("t2_no_accept", 32'(acc_count), 0);
    ready_fix = 1'b1;
    wait_acc("t2_words", 8, 100);
    chk("t2_exp_drained", 32'(exp_q.size()), 0);

    // 3: almost-empty blocks a full burst; flush sends 1-word bursts
    do_reset();
    load(3, 8'h31, 1'b0);
    for (int i = 0; i < 3; i++) exp_last_q.push_back(1'b1);
    wait_cycles(10);
    chk("t3_held_by_ae", 32'(acc_count), 0);
    chk("t3_idle", bus.o_Busy, 0);
    bus.i_Flush = 1'b1;
    wait_acc("t3_words", 3, 100);
    bus.i_Flush = 1'b0;
    chk("t3_bursts", 32'(bursts), 3);

    // 4a: length 0 behaves as 1
    do_reset();
    bus.i_Burst_Len = LEN_W'(0);
    load(3, 8'h41, 1'b0);
    for (int i = 0; i < 3; i++) exp_last_q.push_back(1'b1);
    wait_acc("t4a_words", 3, 100);
    chk("t4a_bursts", 32'(bursts), 3);

    // 4b: length 31 clamps to 16; the remaining 4 need a flush
    do_reset();
    bus.i_Burst_Len = LEN_W'(31);
    load(20, 8'h50, 1'b0);
    for (int i = 0; i < 20; i++) exp_last_q.push_back(i >= 15);
    wait_acc("t4b_burst16", 16, 200);
    wait_cycles(10);
    chk("t4b_stop_at_16", 32'(acc_count), 16);
    chk("t4b_fifo_left", 32'(fifo_q.size()), 4);
    bus.i_Flush = 1'b1;
    wait_acc("t4b_flushed", 20, 200);
    bus.i_Flush = 1'b0;
    chk("t4b_bursts", 32'(bursts), 5);

    // 5: random ready and read latency, 200 random words in bursts of 5
    do_reset();
    bus.i_Burst_Len = LEN_W'(5);
    ready_rand = 1'b1;
    lat_rand   = 1'b1;
    load(200, 0, 1'b1);
    for (int i = 0; i < 200; i++) exp_last_q.push_back(i % 5 == 4);
    wait_acc("t5_words", 200, 5000);
    ready_rand = 1'b0;
    lat_rand   = 1'b0;
    chk("t5_err", bus.o_Err, 0);
    chk("t5_bursts", 32'(bursts), 40);
    chk("t5_exp_drained", 32'(exp_q.size()), 0);

    // 6: reset mid-burst, then a stray data-valid sets the sticky error
    do_reset();
    bus.i_Burst_Len = LEN_W'(4);
    ready_fix = 1'b1;
    load(8, 8'h61, 1'b0);
    exp_q = exp_q[0:1];
    exp_last_q.push_back(1'b0);
    exp_last_q.push_back(1'b0);
    wait_acc("t6_two_words", 2, 100);
    @(negedge clk);
    rst_l = 1'b0;
    clear_model();
    wait_cycles(1);
    chk("t6_dv_dropped", bus.o_Tx_DV, 0);
    chk("t6_no_last", bus.o_Tx_Last, 0);
    chk("t6_idle", bus.o_Busy, 0);
    chk("t6_no_rd", bus.o_Rd_En, 0);
    @(negedge clk);
    rst_l = 1'b1;
    wait_cycles(2);
    chk("t6_err_clear", bus.o_Err, 0);
    inject = 1'b1;
    wait_cycles(2);
    chk("t6_err_set", bus.o_Err, 1);
    wait_cycles(3);
    chk("t6_err_sticky", bus.o_Err, 1);
    chk("t6_stray_not_sent", bus.o_Tx_DV, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
